// File: rtl/conv_layer_seq_pkg.sv
// rtl/conv_layer_seq_pkg.sv - shared types and constants for the layer sequencer
package conv_layer_seq_pkg;
    typedef logic [7:0]  u8_t;
    typedef logic [23:0] u24_t;
    typedef logic [31:0] u32_t;

    localparam int PADR_LANE0       = 24;
    localparam int PADR_LAST_COMMON = 22;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_NEXT
    } seq_state_t;
endpackage

// File: rtl/conv_desc_ram.sv
// rtl/conv_desc_ram.sv - descriptor store, host write port and 1-cycle synchronous read port
module conv_desc_ram
    import conv_layer_seq_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  u32_t          wdata,
    input  logic [AW-1:0] raddr,
    output u32_t          rdata
);
    u32_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_layer_seq.sv
// rtl/conv_layer_seq.sv - streams per-layer descriptors into the address generator and kicks each layer
module conv_layer_seq
    import conv_layer_seq_pkg::*;
#(
    parameter int Np     = 1,
    parameter int NLAYER = 16,
    parameter int RUN_TO = 1024
) (
    input  logic                        aclk,
    input  logic                        arst_n,
    input  logic                        hwe,
    input  logic [$clog2(NLAYER)+4:0]   hadr,
    input  logic [31:0]                 hdata,
    input  logic                        start,
    input  logic [$clog2(NLAYER):0]     n_layers,
    input  logic                        abort,
    input  logic                        run,
    output logic                        pwe,
    output logic [7:0]                  padr,
    output logic [31:0]                 pdata,
    output logic                        kick,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        aborted,
    output logic [$clog2(NLAYER)-1:0]   cur_layer,
    output logic [23:0]                 layer_cyc
);
    localparam int         LW      = $clog2(NLAYER);
    localparam logic [4:0] LAST_W  = 5'(PADR_LANE0 + Np - 1);
    localparam logic [4:0] LAST_CW = 5'(PADR_LAST_COMMON);
    localparam u24_t       TO_LAST = u24_t'(RUN_TO - 1);

    seq_state_t    state;
    logic [4:0]    widx;
    logic [LW:0]   n_lat;
    logic          abort_pend;
    u24_t          cnt;
    u24_t          cnt_inc;
    u32_t          ram_rdata;

    conv_desc_ram #(.AW(LW + 5)) u_ram (
        .clk   (aclk),
        .we    (hwe & ~busy),
        .waddr (hadr),
        .wdata (hdata),
        .raddr ({cur_layer, widx}),
        .rdata (ram_rdata)
    );

    // RAM output is unregistered by reset, so gate it to keep pdata quiet outside writes
    assign pdata = pwe ? ram_rdata : 32'd0;

    always_comb begin
        cnt_inc = (cnt == 24'hFF_FFFF) ? cnt : cnt + 24'd1;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            widx       <= '0;
            n_lat      <= '0;
            abort_pend <= 1'b0;
            cnt        <= '0;
            pwe        <= 1'b0;
            padr       <= '0;
            kick       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            aborted    <= 1'b0;
            cur_layer  <= '0;
            layer_cyc  <= '0;
        end else begin
            pwe  <= 1'b0;
            kick <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat      <= n_layers;
                        cur_layer  <= '0;
                        err        <= 1'b0;
                        aborted    <= 1'b0;
                        abort_pend <= 1'b0;
                        widx       <= '0;
                        if (n_layers == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        // padr tracks the read issued this cycle so it lines up with rdata
                        pwe  <= 1'b1;
                        padr <= {3'b000, widx};
                        if (widx == LAST_W)
                            state <= S_KICK;
                        else if (widx == LAST_CW)
                            widx <= 5'(PADR_LANE0);
                        else
                            widx <= widx + 5'd1;
                    end
                end
                S_KICK: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        kick  <= 1'b1;
                        cnt   <= '0;
                        state <= S_WAIT_RISE;
                    end
                end
                S_WAIT_RISE: begin
                    cnt <= cnt_inc;
                    if (abort)
                        abort_pend <= 1'b1;
                    if (run) begin
                        state <= S_WAIT_FALL;
                    end else if (cnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= S_NEXT;
                    end
                end
                S_WAIT_FALL: begin
                    cnt <= cnt_inc;
                    if (abort)
                        abort_pend <= 1'b1;
                    if (!run) begin
                        layer_cyc <= cnt;
                        state     <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (abort_pend || abort || (({1'b0, cur_layer} + (LW+1)'(1)) == n_lat)) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        aborted <= abort_pend | abort;
                        state   <= S_IDLE;
                    end else begin
                        cur_layer <= cur_layer + LW'(1);
                        widx      <= '0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_layer_seq.sv
// tb/tb_conv_layer_seq.sv - randomized self-checking bench for conv_layer_seq
module tb_conv_layer_seq;
    localparam int NP = 2;
    localparam int NL = 16;
    localparam int LW = 4;
    localparam int NW = 23 + NP;

    logic          aclk = 1'b0;
    logic          arst_n = 1'b0;
    logic          hwe = 1'b0;
    logic [LW+4:0] hadr = '0;
    logic [31:0]   hdata = '0;
    logic          start = 1'b0;
    logic [LW:0]   n_layers = '0;
    logic          abort = 1'b0;
    logic          run;
    logic          pwe, kick, busy, done, err, aborted;
    logic [7:0]    padr;
    logic [31:0]   pdata;
    logic [LW-1:0] cur_layer;
    logic [23:0]   layer_cyc;

    conv_layer_seq #(.Np(NP), .NLAYER(NL), .RUN_TO(1024)) dut (
        .aclk(aclk), .arst_n(arst_n), .hwe(hwe), .hadr(hadr), .hdata(hdata),
        .start(start), .n_layers(n_layers), .abort(abort), .run(run),
        .pwe(pwe), .padr(padr), .pdata(pdata), .kick(kick), .busy(busy),
        .done(done), .err(err), .aborted(aborted), .cur_layer(cur_layer),
        .layer_cyc(layer_cyc)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem [NL][32];
    int          rise_d = 5;
    int          fall_d = 50;
    bit          resp_on = 1'b1;

    int          pq_adr[$];
    int          pq_layer[$];
    logic [31:0] pq_dat[$];
    time         pq_t[$];
    time         kq_t[$];
    time         fall_q[$];
    time         err_q[$];
    int          done_n = 0;
    time         done_t = 0;
    logic        done_ab = 1'b0;
    int          busy_cyc = 0;
    logic        err_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // event recorder: the only writer of the observation queues
    always @(negedge aclk) begin
        if (pwe) begin
            pq_adr.push_back(int'(padr));
            pq_dat.push_back(pdata);
            pq_layer.push_back(int'(cur_layer));
            pq_t.push_back($time);
        end
        if (kick) kq_t.push_back($time);
        if (done) begin
            done_n++;
            done_t  = $time;
            done_ab = aborted;
        end
        if (busy) busy_cyc++;
        if (err && !err_prev) err_q.push_back($time);
        err_prev = err;
    end

    // address-generator stand-in: raises run rise_d cycles after kick, drops it fall_d cycles after kick
    initial begin
        run = 1'b0;
        forever begin
            @(negedge aclk);
            if (kick && resp_on) begin
                repeat (rise_d) @(negedge aclk);
                run = 1'b1;
                repeat (fall_d - rise_d) @(negedge aclk);
                run = 1'b0;
                fall_q.push_back($time);
            end
        end
    end

    task automatic hwrite(input int s, input int w, input logic [31:0] d, input bit model);
        @(negedge aclk);
        hwe   = 1'b1;
        hadr  = {4'(s), 5'(w)};
        hdata = d;
        @(negedge aclk);
        hwe = 1'b0;
        if (model) mem[s][w] = d;
    endtask

    task automatic wait_done(input int db, input int bound);
        int i;
        i = 0;
        while (done_n == db && i < bound) begin
            @(negedge aclk);
            i++;
        end
        if (done_n == db) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_kick(input int kb, input int bound);
        int i;
        i = 0;
        while (kq_t.size() == kb && i < bound) begin
            @(negedge aclk);
            i++;
        end
        if (kq_t.size() == kb) chk("kick_timeout", 0, 1);
    endtask

    task automatic pulse_start(input int n);
        @(negedge aclk);
        start    = 1'b1;
        n_layers = (LW+1)'(n);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {pwe, kick, busy, done, err, aborted}, 6'd0);
        chk({tag, "_padr"}, padr, 0);
        chk({tag, "_pdata"}, pdata, 0);
        chk({tag, "_layer"}, cur_layer, 0);
        chk({tag, "_cyc"}, layer_cyc, 0);
    endtask

    task automatic do_run(input int n, input bit timeout);
        int  pb, kb, fb, db, bb, eb;
        time ts;
        pb = pq_adr.size(); kb = kq_t.size(); fb = fall_q.size();
        db = done_n; bb = busy_cyc; eb = err_q.size();
        pulse_start(n);
        ts = $time;
        @(negedge aclk);
        start = 1'b0;
        wait_done(db, 6000);
        repeat (2) @(negedge aclk);
        chk("n_pwe", pq_adr.size() - pb, n * NW);
        chk("n_kick", kq_t.size() - kb, n);
        chk("n_done", done_n - db, 1);
        chk("aborted", done_ab, 0);
        chk("err", err, timeout);
        chk("busy_end", busy, 0);
        if (n == 0) begin
            chk("busy_n0", busy_cyc - bb, 0);
            chk("done_lat_n0", (done_t - ts) / 10, 1);
        end else if (pq_adr.size() - pb == n * NW && kq_t.size() - kb == n) begin
            chk("first_pwe_lat", (pq_t[pb] - ts) / 10, 2);
            for (int l = 0; l < n; l++) begin
                for (int j = 0; j < NW; j++) begin
                    automatic int w = (j <= 22) ? j : j + 1;
                    automatic int k = pb + l * NW + j;
                    chk("padr", pq_adr[k], w);
                    chk("pdata", pq_dat[k], mem[l][w]);
                    chk("cur_layer", pq_layer[k], l);
                    chk("pwe_gap", (pq_t[k] - pq_t[pb + l * NW]) / 10, j);
                end
                chk("kick_lat", (kq_t[kb + l] - pq_t[pb + l * NW + NW - 1]) / 10, 1);
                if (!timeout && l > 0 && fall_q.size() - fb >= l)
                    chk("fall_to_pwe", (pq_t[pb + l * NW] - fall_q[fb + l - 1]) / 10, 3);
            end
            if (timeout) begin
                if (err_q.size() > eb)
                    chk("err_lat", (err_q[eb] - kq_t[kb]) / 10, 1024);
                else
                    chk("err_rise", 0, 1);
            end else if (fall_q.size() - fb == n) begin
                chk("done_lat", (done_t - fall_q[fb + n - 1]) / 10, 2);
                chk("layer_cyc", layer_cyc, fall_d);
            end
        end
    endtask

    initial begin
        int  pb, kb, db, n;
        time ta;

        #1;
        check_zero("reset");
        repeat (3) @(negedge aclk);
        arst_n = 1'b1;

        for (int s = 0; s < NL; s++)
            for (int w = 0; w < 32; w++)
                hwrite(s, w, (s == 0) ? 32'(w + 100) : $urandom, 1'b1);

        rise_d = 5; fall_d = 50;
        do_run(1, 1'b0);
        do_run(0, 1'b0);
        do_run(3, 1'b0);

        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(2, 4));
            rise_d = int'($urandom_range(1, 10));
            fall_d = rise_d + int'($urandom_range(1, 40));
            for (int s = 0; s < n; s++)
                for (int w = 0; w < 32; w++)
                    hwrite(s, w, $urandom, 1'b1);
            do_run(n, 1'b0);
        end

        resp_on = 1'b0;
        do_run(2, 1'b1);
        resp_on = 1'b1;
        rise_d = 3; fall_d = 20;
        do_run(1, 1'b0);

        // abort while descriptors are still streaming
        pb = pq_adr.size(); kb = kq_t.size(); db = done_n;
        pulse_start(2);
        @(negedge aclk);
        start = 1'b0;
        repeat (2) @(negedge aclk);
        abort = 1'b1;
        ta = $time;
        @(negedge aclk);
        abort = 1'b0;
        wait_done(db, 100);
        repeat (2) @(negedge aclk);
        chk("abl_kick", kq_t.size() - kb, 0);
        chk("abl_done", done_n - db, 1);
        chk("abl_aborted", done_ab, 1);
        chk("abl_lat", (done_t - ta) / 10, 1);
        chk("abl_pwe", pq_adr.size() - pb, 2);
        chk("abl_busy", busy, 0);

        // abort while the layer is running: layer 0 completes, no second load
        rise_d = 5; fall_d = 30;
        pb = pq_adr.size(); kb = kq_t.size(); db = done_n;
        pulse_start(2);
        @(negedge aclk);
        start = 1'b0;
        wait_kick(kb, 200);
        repeat (10) @(negedge aclk);
        abort = 1'b1;
        @(negedge aclk);
        abort = 1'b0;
        wait_done(db, 500);
        repeat (5) @(negedge aclk);
        chk("abf_pwe", pq_adr.size() - pb, NW);
        chk("abf_kick", kq_t.size() - kb, 1);
        chk("abf_done", done_n - db, 1);
        chk("abf_aborted", done_ab, 1);
        chk("abf_cyc", layer_cyc, 30);

        // reset mid-run after a host write that must be dropped while busy
        rise_d = 5; fall_d = 60;
        kb = kq_t.size();
        pulse_start(2);
        @(negedge aclk);
        start = 1'b0;
        wait_kick(kb, 200);
        repeat (15) @(negedge aclk);
        chk("rst_busy_pre", busy, 1);
        hwrite(0, 3, 32'hDEAD_BEEF, 1'b0);
        #3 arst_n = 1'b0;
        #1 check_zero("async_rst");
        repeat (2) @(negedge aclk);
        arst_n = 1'b1;
        repeat (80) @(negedge aclk);
        do_run(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
